// File: rtl/video_timing_tx_pkg.sv
// Shared video-pipeline definitions: stream FSM encoding, default 1280x720 timing
// and a small range-decode helper used by the timing blocks.
package video_timing_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } vt_state_e;

    localparam logic [11:0] DEF_H_DISP  = 12'd1280;
    localparam logic [11:0] DEF_V_DISP  = 12'd720;
    localparam logic [11:0] DEF_H_FRONT = 12'd110;
    localparam logic [11:0] DEF_H_SYNC  = 12'd40;
    localparam logic [11:0] DEF_H_BACK  = 12'd220;
    localparam logic [11:0] DEF_V_FRONT = 12'd5;
    localparam logic [11:0] DEF_V_SYNC  = 12'd5;
    localparam logic [11:0] DEF_V_BACK  = 12'd20;
    localparam int          CNT_LIMIT   = 4095;

    function automatic logic in_range(input logic [11:0] val, input logic [11:0] lo,
                                      input logic [11:0] hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// Horizontal/vertical position counters and region decode for the video transmitter.
module video_timing_cnt
    import video_timing_tx_pkg::*;
#(
    parameter logic [11:0] H_DISP  = DEF_H_DISP,
    parameter logic [11:0] V_DISP  = DEF_V_DISP,
    parameter logic [11:0] H_FRONT = DEF_H_FRONT,
    parameter logic [11:0] H_SYNC  = DEF_H_SYNC,
    parameter logic [11:0] H_BACK  = DEF_H_BACK,
    parameter logic [11:0] V_FRONT = DEF_V_FRONT,
    parameter logic [11:0] V_SYNC  = DEF_V_SYNC,
    parameter logic [11:0] V_BACK  = DEF_V_BACK
) (
    input  logic        clk_vp,
    input  logic        rst_n,
    input  logic        run,
    output logic [11:0] h_cnt,
    output logic [11:0] v_cnt,
    output logic        act_region,
    output logic        vs_region,
    output logic        frame_end
);

    localparam int H_TOTAL = 32'(H_DISP) + 32'(H_FRONT) + 32'(H_SYNC) + 32'(H_BACK);
    localparam int V_TOTAL = 32'(V_DISP) + 32'(V_FRONT) + 32'(V_SYNC) + 32'(V_BACK);
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] VS_START = 12'(32'(V_DISP) + 32'(V_FRONT));
    localparam logic [11:0] VS_END   = 12'(32'(V_DISP) + 32'(V_FRONT) + 32'(V_SYNC));

    if (H_TOTAL > CNT_LIMIT || V_TOTAL > CNT_LIMIT) begin : g_bad_timing
        $error("video_timing_cnt: H_TOTAL/V_TOTAL exceed the 12-bit counter range");
    end

    logic [11:0] h_cnt_d, h_cnt_q;
    logic [11:0] v_cnt_d, v_cnt_q;
    logic        line_end_s;

    // Next position: held at origin while stopped, raster-scan wrap while running
    always_comb begin
        line_end_s = (h_cnt_q == H_LAST);
        h_cnt_d    = 12'd0;
        v_cnt_d    = 12'd0;
        if (!run) begin
            h_cnt_d = 12'd0;
            v_cnt_d = 12'd0;
        end else if (line_end_s) begin
            h_cnt_d = 12'd0;
            v_cnt_d = (v_cnt_q == V_LAST) ? 12'd0 : v_cnt_q + 12'd1;
        end else begin
            h_cnt_d = h_cnt_q + 12'd1;
            v_cnt_d = v_cnt_q;
        end
    end

    // Position registers
    always_ff @(posedge clk_vp or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= 12'd0;
            v_cnt_q <= 12'd0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt      = h_cnt_q;
    assign v_cnt      = v_cnt_q;
    assign act_region = (h_cnt_q < H_DISP) && (v_cnt_q < V_DISP);
    assign vs_region  = in_range(v_cnt_q, VS_START, VS_END);
    assign frame_end  = line_end_s && (v_cnt_q == V_LAST);

endmodule

// File: rtl/video_timing_tx.sv
// Video timing transmitter: pulls RGB565 pixels from a source and emits
// registered vs/de/data with frame_start and a sticky underflow flag.
module video_timing_tx
    import video_timing_tx_pkg::*;
#(
    parameter logic [11:0] H_DISP  = DEF_H_DISP,
    parameter logic [11:0] V_DISP  = DEF_V_DISP,
    parameter logic [11:0] H_FRONT = DEF_H_FRONT,
    parameter logic [11:0] H_SYNC  = DEF_H_SYNC,
    parameter logic [11:0] H_BACK  = DEF_H_BACK,
    parameter logic [11:0] V_FRONT = DEF_V_FRONT,
    parameter logic [11:0] V_SYNC  = DEF_V_SYNC,
    parameter logic [11:0] V_BACK  = DEF_V_BACK
) (
    input  logic        clk_vp,
    input  logic        rst_n,
    input  logic        en,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    output logic        pix_ready,
    output logic        vo_vs,
    output logic        vo_de,
    output logic [15:0] vo_data,
    output logic        frame_start,
    output logic        underflow,
    input  logic        clr_underflow
);

    vt_state_e   state_d, state_q;
    logic        vo_vs_d, vo_vs_q;
    logic        vo_de_d, vo_de_q;
    logic [15:0] vo_data_d, vo_data_q;
    logic        frame_start_d, frame_start_q;
    logic        underflow_d, underflow_q;

    logic        run_s, active_s;
    logic [11:0] h_cnt_s, v_cnt_s;
    logic        act_region_s, vs_region_s, frame_end_s;

    video_timing_cnt #(
        .H_DISP (H_DISP),  .V_DISP (V_DISP),
        .H_FRONT(H_FRONT), .H_SYNC (H_SYNC), .H_BACK(H_BACK),
        .V_FRONT(V_FRONT), .V_SYNC (V_SYNC), .V_BACK(V_BACK)
    ) u_cnt (
        .clk_vp    (clk_vp),
        .rst_n     (rst_n),
        .run       (run_s),
        .h_cnt     (h_cnt_s),
        .v_cnt     (v_cnt_s),
        .act_region(act_region_s),
        .vs_region (vs_region_s),
        .frame_end (frame_end_s)
    );

    assign run_s     = (state_q != ST_IDLE);
    assign active_s  = run_s && act_region_s;
    assign pix_ready = active_s;

    // Stream FSM: a stop request drains the current frame before idling
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = en ? ST_RUN : ST_IDLE;
            ST_RUN: begin
                if (en) begin
                    state_d = ST_RUN;
                end else if (frame_end_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (en) begin
                    state_d = ST_RUN;
                end else if (frame_end_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output next-state; a starved active slot still emits de with black data
    always_comb begin
        vo_de_d       = active_s;
        vo_data_d     = (active_s && pix_valid) ? pix_data : 16'h0000;
        vo_vs_d       = run_s && vs_region_s;
        frame_start_d = active_s && (h_cnt_s == 12'd0) && (v_cnt_s == 12'd0);
        if (active_s && !pix_valid) begin
            underflow_d = 1'b1;
        end else if (clr_underflow) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk_vp or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            vo_vs_q       <= 1'b0;
            vo_de_q       <= 1'b0;
            vo_data_q     <= 16'h0000;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            vo_vs_q       <= vo_vs_d;
            vo_de_q       <= vo_de_d;
            vo_data_q     <= vo_data_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
        end
    end

    assign vo_vs       = vo_vs_q;
    assign vo_de       = vo_de_q;
    assign vo_data     = vo_data_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_video_timing_tx.sv
// Directed bench for video_timing_tx on a 4x2 active raster (7x5 total, 35 cycles per frame).
module tb_video_timing_tx;

    logic        clk_vp = 1'b0;
    logic        rst_n;
    logic        en;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        clr_underflow;
    logic        pix_ready;
    logic        vo_vs;
    logic        vo_de;
    logic [15:0] vo_data;
    logic        frame_start;
    logic        underflow;

    logic [15:0] src_q;
    int          n_checks = 0;
    int          n_fail   = 0;

    video_timing_tx #(
        .H_DISP (12'd4), .V_DISP (12'd2),
        .H_FRONT(12'd1), .H_SYNC (12'd1), .H_BACK(12'd1),
        .V_FRONT(12'd1), .V_SYNC (12'd1), .V_BACK(12'd1)
    ) dut (
        .clk_vp       (clk_vp),
        .rst_n        (rst_n),
        .en           (en),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .pix_ready    (pix_ready),
        .vo_vs        (vo_vs),
        .vo_de        (vo_de),
        .vo_data      (vo_data),
        .frame_start  (frame_start),
        .underflow    (underflow),
        .clr_underflow(clr_underflow)
    );

    always #5 clk_vp = ~clk_vp;

    // Pixel source: word sequence 1,2,3... advancing only on a handshake
    always @(posedge clk_vp or negedge rst_n) begin
        if (!rst_n) begin
            src_q <= 16'd1;
        end else if (pix_ready && pix_valid) begin
            src_q <= src_q + 16'd1;
        end
    end
    assign pix_data = src_q;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_vp);
        #1;
    endtask

    task automatic wait_fs();
        int  i  = 0;
        while (!frame_start && i < 100) begin
            tick();
            i++;
        end
        chk("fs_timeout", 32'(frame_start), 32'd1);
    endtask

    // Checks one frame sample-by-sample; sample s shows the output of raster position s.
    // Inputs set at sample s apply to position s+1, which the DUT presents in that cycle.
    task automatic check_frame(input logic [15:0] first_word, input logic u_in,
                               input int ufl_pos, input int clr_pos, input int drop_pos);
        logic [15:0] exp_w;
        logic        exp_u;
        logic        exp_de;
        exp_w = first_word;
        exp_u = u_in;
        wait_fs();
        for (int s = 0; s < 35; s++) begin
            if (s > 0) tick();
            pix_valid     = (s + 1 != ufl_pos);
            clr_underflow = (s + 1 == clr_pos);
            if (s + 1 == drop_pos) en = 1'b0;
            if (s == ufl_pos) exp_u = 1'b1;
            else if (s == clr_pos) exp_u = 1'b0;
            exp_de = ((s % 7) < 4) && ((s / 7) < 2);
            chk("de", 32'(vo_de), 32'(exp_de));
            chk("vs", 32'(vo_vs), 32'((s / 7) == 3));
            chk("fs", 32'(frame_start), 32'(s == 0));
            chk("ufl", 32'(underflow), 32'(exp_u));
            if (exp_de && s == ufl_pos) begin
                chk("data_starved", 32'(vo_data), 32'h0);
            end else if (exp_de) begin
                chk("data", 32'(vo_data), 32'(exp_w));
                exp_w = exp_w + 16'd1;
            end else begin
                chk("data_blank", 32'(vo_data), 32'h0);
            end
        end
        tick();
        chk("fs_next", 32'(frame_start), 32'(drop_pos < 0));
    endtask

    initial begin
        rst_n         = 1'b0;
        en            = 1'b0;
        pix_valid     = 1'b1;
        clr_underflow = 1'b0;
        repeat (2) tick();
        chk("rst_de", 32'(vo_de), 32'd0);
        chk("rst_vs", 32'(vo_vs), 32'd0);
        chk("rst_data", 32'(vo_data), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        chk("rst_ufl", 32'(underflow), 32'd0);
        chk("rst_ready", 32'(pix_ready), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_ready", 32'(pix_ready), 32'd0);
        chk("idle_de", 32'(vo_de), 32'd0);

        en = 1'b1;
        check_frame(16'd1,  1'b0, -1, -1, -1);  // words 1..8
        check_frame(16'd9,  1'b0,  1,  5, -1);  // starve 2nd pixel, clear later
        check_frame(16'd16, 1'b0,  2,  2, -1);  // set and clear together
        check_frame(16'd23, 1'b1, -1,  3,  9);  // stop requested at line 1 pixel 2

        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stop_ready", 32'(pix_ready), 32'd0);
            chk("stop_de", 32'(vo_de), 32'd0);
            chk("stop_vs", 32'(vo_vs), 32'd0);
            chk("stop_data", 32'(vo_data), 32'd0);
            chk("stop_fs", 32'(frame_start), 32'd0);
        end

        en = 1'b1;
        check_frame(16'd31, 1'b0, -1, -1, -1);

        // Next frame is running; abandon it mid active line
        tick();
        tick();
        chk("pre_rst_de", 32'(vo_de), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_de", 32'(vo_de), 32'd0);
        chk("arst_data", 32'(vo_data), 32'd0);
        chk("arst_vs", 32'(vo_vs), 32'd0);
        chk("arst_fs", 32'(frame_start), 32'd0);
        chk("arst_ufl", 32'(underflow), 32'd0);
        chk("arst_ready", 32'(pix_ready), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("in_rst_ready", 32'(pix_ready), 32'd0);
            chk("in_rst_de", 32'(vo_de), 32'd0);
        end
        rst_n = 1'b1;
        check_frame(16'd1, 1'b0, -1, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/video_timing_tx.md
VIDEO_TIMING_TX -- requirements
Module: video_timing_tx

Interface
REQ-001 SHALL have parameter H_DISP, default 12'd1280, active pixels per line.
REQ-002 SHALL have parameter V_DISP, default 12'd720, active lines per frame.
REQ-003 SHALL have parameters H_FRONT=110, H_SYNC=40, H_BACK=220, V_FRONT=5, V_SYNC=5, V_BACK=20, the blanking widths in pixels/lines.
REQ-004 SHALL have ports clk_vp input 1, the only clock; and rst_n input 1, the reset, asynchronous and active-low.
REQ-005 SHALL have port en input 1, the stream enable.
REQ-006 SHALL have ports pix_valid input 1 and pix_data input 16, the RGB565 pixel source.
REQ-007 SHALL have port pix_ready output 1, the pixel pull strobe.
REQ-008 SHALL have ports vo_vs output 1, vo_de output 1 and vo_data output 16, the video output in vi_vs/vi_de/vi_data format.
REQ-009 SHALL have port frame_start output 1, a one-cycle pulse at pixel (0,0).
REQ-010 SHALL have ports underflow output 1, sticky; and clr_underflow input 1, which clears it.

Function
REQ-011 SHALL define H_TOTAL=H_DISP+H_FRONT+H_SYNC+H_BACK and V_TOTAL=V_DISP+V_FRONT+V_SYNC+V_BACK; both SHALL be at most 4095, checked at elaboration.
REQ-012 SHALL use 12-bit counters h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1).
REQ-013 h_cnt SHALL wrap to 0 after H_TOTAL-1; v_cnt SHALL increment on that wrap and wrap to 0 after V_TOTAL-1.
REQ-014 Region order per line and per frame SHALL be: active, front porch, sync, back porch.
REQ-015 active SHALL be h_cnt<H_DISP && v_cnt<V_DISP && state==RUN/STOP.
REQ-016 pix_ready SHALL equal active, combinational from the counters/state only and never dependent on pix_valid.
REQ-017 A pixel SHALL be consumed only in a cycle where pix_ready && pix_valid.
REQ-018 All vo_* outputs SHALL be registered, with 1-cycle latency from the counter state.
REQ-019 A pixel accepted in cycle N SHALL appear on vo_data with vo_de=1 in cycle N+1.
REQ-020 vo_de(N+1) SHALL equal active(N).
REQ-021 vo_vs SHALL be high (active-high) for whole lines with V_DISP+V_FRONT <= v_cnt < V_DISP+V_FRONT+V_SYNC, registered.
REQ-022 No horizontal sync output SHALL exist.
REQ-023 Underflow: in a cycle with active && !pix_valid, the next cycle SHALL still have vo_de=1 and vo_data SHALL be 16'h0000.
REQ-024 On underflow, underflow SHALL set; pixel position SHALL advance regardless.
REQ-025 underflow SHALL clear on clr_underflow.
REQ-026 If set and clear coincide, set SHALL win.
REQ-027 When inactive, vo_data SHALL be 16'h0000.
REQ-028 State machine states: IDLE, RUN, STOP.
REQ-029 IDLE: counters SHALL be held at 0 and all outputs SHALL be 0; en=1 SHALL transition to RUN with (0,0) presented in the next cycle.
REQ-030 RUN: en=0 SHALL transition to STOP with no other effect.
REQ-031 STOP: SHALL finish the current frame; at the frame wrap (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1) it SHALL go to IDLE.
REQ-032 STOP: if en=1 reasserts before the frame wrap, it SHALL return to RUN without a gap.
REQ-033 frame_start SHALL be registered and high in the same cycle as the vo_de of pixel (0,0).

Reset
REQ-034 rst_n low SHALL immediately force: state=IDLE, h_cnt=v_cnt=0, vo_vs=vo_de=0, vo_data=0, frame_start=0, underflow=0, pix_ready=0.
REQ-035 Reset mid-frame SHALL abandon the frame; no pixel SHALL be consumed while rst_n=0.

Structure
REQ-036 State encoding (IDLE/RUN/STOP) and default 1280x720 timing constants SHALL reside in the shared video package used by the VP blocks.
REQ-037 A single sub-module, video_timing_cnt (h/v counters plus region decode), SHALL be used; the FSM and output registers SHALL reside in the top.

Verification (bench params: H_DISP=4, V_DISP=2, all porch/sync=1 -> H_TOTAL=7, V_TOTAL=5)
REQ-038 Scenario: reset, en=1, pix_valid=1 with incrementing data 1,2,3... -> vo_de high 4 cycles per line, 2 lines; vo_data 1..8 in order; 35 cycles per frame; frame_start pulse every 35 cycles.
REQ-039 Scenario: observe vo_vs -> high exactly 7 consecutive cycles (line v_cnt=3) per frame, never overlapping vo_de.
REQ-040 Scenario: pix_valid=0 for the 2nd active pixel of line 0 -> vo_data=0x0000 with vo_de=1 in that slot; underflow=1 afterwards; next pixel is the next source word; clr_underflow -> 0.
REQ-041 Scenario: en dropped at line 1 pixel 2 -> remainder of frame output intact, then IDLE; outputs 0 and pix_ready=0 until en=1.
REQ-042 Scenario: rst_n asserted mid-active-line -> all outputs 0 the same cycle; after release with en=1, first vo_de pixel is frame (0,0) with frame_start.
REQ-043 Scenario: underflow set and clr_underflow in the same cycle -> underflow remains 1.
